regfile_wb: RTL and testbench

Integer register file that is the receiving end of the writeback stage's WB→ID interface. It commits `rd`/`res`/`regwrite` results into 31 general registers (x0 is hardwired to zero) and serves two combinational decode read ports with same-cycle write bypass. It also provides a four-phase debug access port, active while the core is halted, and a retired-write counter. It sits in the decode stage, beside the hazard/forwarding logic.

---
 rtl/regfile_wb.sv | 143 ++++++++++++++
 tb/tb_regfile_wb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb.sv
// Decode-stage integer register file fed by the writeback commit port.
// Two bypassed read ports, a halted-core debug port and a commit counter.
module regfile_wb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            WB_ID_regwrite,
  input  logic [AW-1:0]   WB_ID_rd,
  input  logic [XLEN-1:0] WB_ID_res,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            dbg,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_ack,
  output logic [XLEN-1:0] dbg_rdata,
  output logic [31:0]     wb_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } dbg_state_e;

  dbg_state_e state_q, state_d;

  logic [XLEN-1:0] regs_q [NREG];
  logic [31:0]     wb_count_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;

  logic commit;
  logic lat_en;
  logic acc_en;
  logic dbg_wr;
  logic dbg_rd;

  assign commit = WB_ID_regwrite && (WB_ID_rd != '0);
  assign dbg_wr = acc_en && we_q && (addr_q != '0);
  assign dbg_rd = acc_en && !we_q;

  always_comb begin
    state_d = state_q;
    lat_en  = 1'b0;
    acc_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dbg && dbg_req) begin
          state_d = S_BUSY;
          lat_en  = 1'b1;
        end
      end
      S_BUSY: begin
        // pipeline commits own the write port; the debug access waits
        if (!dbg) begin
          state_d = S_IDLE;
        end else if (!WB_ID_regwrite) begin
          state_d = S_DONE;
          acc_en  = 1'b1;
        end
      end
      S_DONE: begin
        if (!dbg || !dbg_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (lat_en) begin
        we_q    <= dbg_we;
        addr_q  <= dbg_addr;
        wdata_q <= dbg_wdata;
      end
      if (dbg_rd) begin
        rdata_q <= (addr_q == '0) ? '0 : regs_q[addr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      if (commit) begin
        regs_q[WB_ID_rd] <= WB_ID_res;
        wb_count_q       <= wb_count_q + 32'd1;
      end else if (dbg_wr) begin
        regs_q[addr_q] <= wdata_q;
      end
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) begin
      if (WB_ID_regwrite && (WB_ID_rd == rs1_addr)) begin
        rs1_data = WB_ID_res;
      end else begin
        rs1_data = regs_q[rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0) begin
      if (WB_ID_regwrite && (WB_ID_rd == rs2_addr)) begin
        rs2_data = WB_ID_res;
      end else begin
        rs2_data = regs_q[rs2_addr];
      end
    end
  end

  assign dbg_ack   = (state_q == S_DONE);
  assign dbg_rdata = rdata_q;
  assign wb_count  = wb_count_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: commits, bypass, debug port,
// collision stalls, abort and counter wrap.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        Rst;
  logic        WB_ID_regwrite;
  logic [4:0]  WB_ID_rd;
  logic [31:0] WB_ID_res;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        dbg, dbg_req, dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [31:0] wb_count;

  regfile_wb dut (
    .clk(clk),
    .Rst(Rst),
    .WB_ID_regwrite(WB_ID_regwrite),
    .WB_ID_rd(WB_ID_rd),
    .WB_ID_res(WB_ID_res),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .dbg(dbg),
    .dbg_req(dbg_req),
    .dbg_we(dbg_we),
    .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack),
    .dbg_rdata(dbg_rdata),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef enum {O_RS1, O_RS2, O_ACK, O_RDATA, O_CNT} osel_e;
  typedef struct {
    string       tag;
    osel_e       sel;
    logic [31:0] exp;
  } sb_t;

  sb_t         sbq[$];
  int          nchk = 0;
  int          nerr = 0;
  logic [31:0] mreg [32];
  logic [31:0] mcnt;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(string t, osel_e s, logic [31:0] v);
    sb_t e;
    e.tag = t;
    e.sel = s;
    e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    logic [31:0] got;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.sel)
        O_RS1:   got = rs1_data;
        O_RS2:   got = rs2_data;
        O_ACK:   got = {31'd0, dbg_ack};
        O_RDATA: got = dbg_rdata;
        default: got = wb_count;
      endcase
      chk(e.tag, got, e.exp);
    end
  endtask

  function automatic logic [31:0] mread(logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (WB_ID_regwrite && WB_ID_rd == a) return WB_ID_res;
    return mreg[a];
  endfunction

  task automatic exp_ports(string t);
    push({t, ".rs1"}, O_RS1, mread(rs1_addr));
    push({t, ".rs2"}, O_RS2, mread(rs2_addr));
    push({t, ".cnt"}, O_CNT, mcnt);
  endtask

  // one clock: model follows pipeline commits, debug effects applied by hand
  task automatic cyc();
    @(posedge clk);
    if (Rst) begin
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      mcnt = 32'd0;
    end else if (WB_ID_regwrite && WB_ID_rd != 5'd0) begin
      mreg[WB_ID_rd] = WB_ID_res;
      mcnt = mcnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic dbg_idle();
    dbg = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    dbg_addr = 5'd0; dbg_wdata = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mcnt = 32'd0;
    Rst = 1'b1;
    WB_ID_regwrite = 1'b0; WB_ID_rd = 5'd0; WB_ID_res = 32'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    dbg_idle();
    @(negedge clk);
    cyc();
    cyc();
    Rst = 1'b0;

    // reset state with x5 preloaded and a commit offered during reset
    WB_ID_regwrite = 1'b1; WB_ID_rd = 5'd5; WB_ID_res = 32'h1234;
    cyc();
    WB_ID_regwrite = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd6;
    push("preload", O_RS1, 32'h1234);
    drain();
    Rst = 1'b1;
    WB_ID_regwrite = 1'b1; WB_ID_rd = 5'd6; WB_ID_res = 32'h55;
    cyc();
    Rst = 1'b0; WB_ID_regwrite = 1'b0;
    push("rst.x5", O_RS1, 32'd0);
    push("rst.x6", O_RS2, 32'd0);
    push("rst.cnt", O_CNT, 32'd0);
    push("rst.ack", O_ACK, 32'd0);
    push("rst.rdata", O_RDATA, 32'd0);
    drain();

    // commit with same-cycle bypass on both ports
    WB_ID_regwrite = 1'b1; WB_ID_rd = 5'd5; WB_ID_res = 32'hDEADBEEF;
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    push("byp.rs1", O_RS1, 32'hDEADBEEF);
    push("byp.rs2", O_RS2, 32'hDEADBEEF);
    drain();
    cyc();
    WB_ID_regwrite = 1'b0;
    push("cmt.rs1", O_RS1, 32'hDEADBEEF);
    push("cmt.rs2", O_RS2, 32'hDEADBEEF);
    push("cmt.cnt", O_CNT, 32'd1);
    drain();

    // x0 is never written and never counted
    WB_ID_regwrite = 1'b1; WB_ID_rd = 5'd0; WB_ID_res = 32'hFFFFFFFF;
    rs1_addr = 5'd0;
    push("x0.byp", O_RS1, 32'd0);
    drain();
    cyc();
    WB_ID_regwrite = 1'b0;
    push("x0.rd", O_RS1, 32'd0);
    push("x0.cnt", O_CNT, 32'd1);
    drain();

    // random commits and independent read ports
    for (int i = 0; i < 40; i++) begin
      WB_ID_regwrite = 1'($urandom_range(0, 1));
      WB_ID_rd  = 5'($urandom_range(0, 31));
      WB_ID_res = $urandom;
      rs1_addr  = ($urandom_range(0, 2) == 0) ? WB_ID_rd : 5'($urandom_range(0, 31));
      rs2_addr  = ($urandom_range(0, 2) == 0) ? WB_ID_rd : 5'($urandom_range(0, 31));
      exp_ports("rnd");
      drain();
      cyc();
    end
    WB_ID_regwrite = 1'b0;
    exp_ports("rnd.end");
    drain();

    // debug read of x7
    WB_ID_regwrite = 1'b1; WB_ID_rd = 5'd7; WB_ID_res = 32'hA5A5A5A5;
    cyc();
    WB_ID_regwrite = 1'b0;
    dbg = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
    push("drd.c0", O_ACK, 32'd0);
    drain();
    cyc();
    push("drd.c1", O_ACK, 32'd0);
    drain();
    cyc();
    push("drd.c2", O_ACK, 32'd1);
    push("drd.data", O_RDATA, 32'hA5A5A5A5);
    drain();
    cyc();
    dbg_req = 1'b0;
    push("drd.hold", O_ACK, 32'd1);
    drain();
    cyc();
    push("drd.drop", O_ACK, 32'd0);
    push("drd.keep", O_RDATA, 32'hA5A5A5A5);
    drain();
    dbg_idle();
    cyc();

    // debug write colliding with three pipeline commits to x9
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
    dbg = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1;
    dbg_addr = 5'd9; dbg_wdata = 32'h11;
    cyc();
    WB_ID_regwrite = 1'b1; WB_ID_rd = 5'd9; WB_ID_res = 32'h22;
    rs1_addr = 5'd9;
    for (int i = 0; i < 3; i++) begin
      push("col.stall", O_ACK, 32'd0);
      push("col.byp", O_RS1, 32'h22);
      drain();
      cyc();
    end
    WB_ID_regwrite = 1'b0;
    push("col.c4", O_ACK, 32'd0);
    drain();
    cyc();
    mreg[9] = 32'h11;
    push("col.ack", O_ACK, 32'd1);
    push("col.x9", O_RS1, 32'h11);
    push("col.cnt", O_CNT, 32'd3);
    drain();
    dbg_req = 1'b0;
    cyc();
    push("col.drop", O_ACK, 32'd0);
    drain();

    // debug write to x0 is acknowledged but has no effect
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFF;
    cyc();
    cyc();
    rs1_addr = 5'd0;
    push("dx0.ack", O_ACK, 32'd1);
    push("dx0.rd", O_RS1, 32'd0);
    push("dx0.cnt", O_CNT, 32'd3);
    drain();
    dbg_req = 1'b0;
    cyc();

    // abort: drop dbg while BUSY
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'hCAFE;
    cyc();
    dbg = 1'b0;
    cyc();
    dbg_req = 1'b0;
    push("abt.ack", O_ACK, 32'd0);
    drain();
    dbg = 1'b1;
    cyc();
    cyc();
    rs1_addr = 5'd12;
    push("abt.idle", O_ACK, 32'd0);
    push("abt.x12", O_RS1, mreg[12]);
    drain();
    dbg_idle();

    // counter wrap
    force dut.wb_count_q = 32'hFFFFFFFF;
    #1;
    release dut.wb_count_q;
    mcnt = 32'hFFFFFFFF;
    WB_ID_regwrite = 1'b1; WB_ID_rd = 5'd3; WB_ID_res = 32'h1;
    cyc();
    WB_ID_regwrite = 1'b0;
    push("wrap.cnt", O_CNT, mcnt);
    push("wrap.zero", O_CNT, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
